hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezing and halt, with saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       IFID_Rs,
  input  logic [2:0]       IFID_Rt,
  input  logic             IFID_useRs,
  input  logic             IFID_useRt,
  input  logic [2:0]       IDEX_Rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_WriteReg,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             halt_wb,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALTED  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     cur_state, nxt_state;
  logic       pend_flush, pend_nxt;
  logic       luh;
  logic       stall_inc, flush_inc;
  logic [4:0] en; // {PC, IFID, IDEX, EXMEM, MEMWB}

  assign state    = cur_state;
  assign PC_en    = en[4];
  assign IFID_en  = en[3];
  assign IDEX_en  = en[2];
  assign EXMEM_en = en[1];
  assign MEMWB_en = en[0];

  // Load-use hazard: a load in EX feeds a register read in ID.
  always_comb begin
    luh = IDEX_MemRead && IDEX_WriteReg && (IDEX_Rd != 3'd0) &&
          ((IFID_useRs && (IDEX_Rd == IFID_Rs)) ||
           (IFID_useRt && (IDEX_Rd == IFID_Rt)));
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    nxt_state   = cur_state;
    pend_nxt    = pend_flush;
    en          = '0;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
      nxt_state   = RUN;
      pend_nxt    = 1'b0;
    end else begin
      case (cur_state)
        RUN: begin
          if (halt_wb) begin
            nxt_state = HALTED;
          end else if (dmem_stall && !dmem_done) begin
            // A simultaneous done means a single-cycle access: fall through to the normal rows.
            nxt_state = MEMWAIT;
            if (branch_taken) pend_nxt = 1'b1;
          end else if (branch_taken) begin
            en          = '1;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            flush_inc   = 1'b1;
          end else if (luh || imem_stall) begin
            en          = 5'b00111;
            IDEX_bubble = 1'b1;
          end else begin
            en = '1;
          end
        end
        MEMWAIT: begin
          if (dmem_done) begin
            en        = '1;
            nxt_state = RUN;
            if (pend_flush) begin
              IFID_flush  = 1'b1;
              IDEX_bubble = 1'b1;
              flush_inc   = 1'b1;
              pend_nxt    = 1'b0;
            end
          end
        end
        HALTED: begin
          nxt_state = HALTED;
        end
        default: begin
          nxt_state = RUN;
          pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign stall_inc = !rst && !PC_en && (cur_state != HALTED);

  // State, pending flush and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= RUN;
      pend_flush <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      cur_state  <= nxt_state;
      pend_flush <= pend_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
